// File: rtl/serial_frame_pkg.sv
// Shared state encoding and width helper for the serial frame detector.
package serial_frame_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HUNT    = 3'd1,
    LEN     = 3'd2,
    PAYLOAD = 3'd3,
    DONE    = 3'd4
  } state_e;

  // Ceiling log2; callers pass max+1 to size a counter that must hold max.
  function automatic int unsigned CLOG2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/serial_pattern_matcher.sv
// Header shift register with fill counter; flags a match only once PAT_W fresh bits are in.
module serial_pattern_matcher
  import serial_frame_pkg::*;
#(
  parameter int unsigned      PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1101
) (
  input  logic clock,
  input  logic rst,
  input  logic clear,
  input  logic shift_en,
  input  logic serialin,
  output logic match
);

  localparam int unsigned FILL_W = CLOG2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);

  logic [PAT_W-1:0]  shreg_q;
  logic [PAT_W-1:0]  candidate;
  logic [PAT_W:0]    shift_ext;
  logic [FILL_W-1:0] fill_q;

  assign shift_ext = {shreg_q, serialin};
  assign candidate = shift_ext[PAT_W-1:0];

  // fill_q counts bits taken before the current one, saturating at PAT_W-1.
  always_ff @(posedge clock) begin
    if (!rst) begin
      shreg_q <= '0;
      fill_q  <= '0;
    end else if (clear) begin
      shreg_q <= '0;
      fill_q  <= '0;
    end else if (shift_en) begin
      shreg_q <= candidate;
      if (fill_q != FILL_FULL) fill_q <= fill_q + FILL_W'(1);
    end
  end

  assign match = shift_en && (fill_q == FILL_FULL) && (candidate == PATTERN);

endmodule

// File: rtl/serial_frame_detector.sv
// Serial frame detector: hunts a header, reads a length field, forwards that many payload
// bits, and counts completed frames with a hunt timeout.
module serial_frame_detector
  import serial_frame_pkg::*;
#(
  parameter int unsigned      PAT_W    = 4,
  parameter logic [PAT_W-1:0] PATTERN  = 4'b1101,
  parameter int unsigned      LEN_W    = 4,
  parameter int unsigned      HUNT_MAX = 32,
  parameter int unsigned      CNT_W    = 8
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             start,
  input  logic             serialin,
  output logic             serialout,
  output logic             out_valid,
  output logic             ready,
  output logic             timeout,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int unsigned HCNT_W = CLOG2(HUNT_MAX + 1);
  localparam int unsigned LCNT_W = CLOG2(LEN_W + 1);

  state_e             state_q, state_d;
  logic [HCNT_W-1:0]  hunt_cnt_q, hunt_cnt_d;
  logic [LCNT_W-1:0]  len_cnt_q, len_cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [LEN_W-1:0]   len_shift;
  logic [LEN_W:0]     len_ext;
  logic               serialout_q, serialout_d;
  logic               out_valid_q, out_valid_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic               hunt_clear;
  logic               hunt_shift;
  logic               hunt_match;

  serial_pattern_matcher #(
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN)
  ) u_matcher (
    .clock    (clock),
    .rst      (rst),
    .clear    (hunt_clear),
    .shift_en (hunt_shift),
    .serialin (serialin),
    .match    (hunt_match)
  );

  assign len_ext   = {len_q, serialin};
  assign len_shift = len_ext[LEN_W-1:0];

  always_comb begin
    state_d     = state_q;
    hunt_cnt_d  = hunt_cnt_q;
    len_cnt_d   = len_cnt_q;
    len_d       = len_q;
    rem_d       = rem_q;
    serialout_d = serialout_q;
    out_valid_d = 1'b0;
    timeout_d   = 1'b0;
    frame_cnt_d = frame_cnt_q;
    hunt_clear  = 1'b0;
    hunt_shift  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = HUNT;
          hunt_cnt_d = '0;
          hunt_clear = 1'b1;
        end
      end
      HUNT: begin
        hunt_shift = 1'b1;
        hunt_cnt_d = hunt_cnt_q + HCNT_W'(1);
        // A match on the last permitted bit takes priority over the timeout.
        if (hunt_match) begin
          state_d   = LEN;
          len_cnt_d = '0;
          len_d     = '0;
        end else if (hunt_cnt_q == HCNT_W'(HUNT_MAX - 1)) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end
      end
      LEN: begin
        len_d     = len_shift;
        len_cnt_d = len_cnt_q + LCNT_W'(1);
        if (len_cnt_q == LCNT_W'(LEN_W - 1)) begin
          rem_d   = len_shift;
          state_d = (len_shift == '0) ? DONE : PAYLOAD;
        end
      end
      PAYLOAD: begin
        serialout_d = serialin;
        out_valid_d = 1'b1;
        rem_d       = rem_q - LEN_W'(1);
        if (rem_q == LEN_W'(1)) state_d = DONE;
      end
      DONE: begin
        if (frame_cnt_q != {CNT_W{1'b1}}) frame_cnt_d = frame_cnt_q + CNT_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      state_q     <= IDLE;
      hunt_cnt_q  <= '0;
      len_cnt_q   <= '0;
      len_q       <= '0;
      rem_q       <= '0;
      serialout_q <= 1'b0;
      out_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      hunt_cnt_q  <= hunt_cnt_d;
      len_cnt_q   <= len_cnt_d;
      len_q       <= len_d;
      rem_q       <= rem_d;
      serialout_q <= serialout_d;
      out_valid_q <= out_valid_d;
      timeout_q   <= timeout_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign ready     = (state_q == IDLE);
  assign serialout = serialout_q;
  assign out_valid = out_valid_q;
  assign timeout   = timeout_q;
  assign frame_cnt = frame_cnt_q;

endmodule
